// File: rtl/glb_stream_pkg.sv
// glb_stream_pkg
// Shared definitions for the 17-bit GLB ready/valid token stream:
// token width, control-field positions, the canonical DONE token,
// the token-kind and sink-state enumerations, and a token decoder.
// Ports: none (package).
package glb_stream_pkg;

  localparam int TOKEN_W  = 17;
  localparam int CTRL_BIT = 16;
  localparam int KIND_MSB = 9;
  localparam int KIND_LSB = 8;

  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  // Literal names carry a prefix so both enums can share one package scope.
  typedef enum logic [1:0] {
    KIND_DATA,
    KIND_STOP,
    KIND_DONE,
    KIND_RSVD
  } token_kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DONE
  } sink_state_t;

  function automatic token_kind_t decode_token(input logic [TOKEN_W-1:0] tok);
    token_kind_t kind;
    kind = KIND_DATA;
    if (tok[CTRL_BIT]) begin
      case (tok[KIND_MSB:KIND_LSB])
        2'b00:   kind = KIND_STOP;
        2'b01:   kind = KIND_DONE;
        default: kind = KIND_RSVD;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/glb_lfsr16.sv
// glb_lfsr16
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
// Shared between the stream sink and a matching source-side block.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset, loads seed
//   en    - advance one step per cycle when high
//   seed  - reset value, must be nonzero
//   state - current LFSR contents
module glb_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic feedback;

  // Tap positions 16,14,13,11 map to bits 0,2,3,5 when shifting right.
  assign feedback = state[0] ^ state[2] ^ state[3] ^ state[5];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= seed;
    end else if (en) begin
      state <= {feedback, state[15:1]};
    end
  end

endmodule

// File: rtl/glb_stream_sink.sv
// glb_stream_sink
// Receiving end of the GLB 17-bit ready/valid token stream for on-chip
// test harnesses. Applies seedable pseudo-random backpressure, captures
// accepted tokens into a readable buffer, counts data/stop tokens and
// active cycles, and raises a sticky done once DONE is accepted.
// Optional watchdog: define GLB_STREAM_SINK_TIMEOUT_EN.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   clk_en       - all state holds and ready is 0 when low
//   flush        - synchronous clear, same effect as reset
//   data, valid  - incoming token and its valid
//   ready        - sink ready (never depends on valid)
//   done         - sticky, DONE token accepted
//   rd_addr      - capture buffer read address
//   rd_data      - capture buffer data, registered one cycle
//   data_count   - accepted data tokens (saturating)
//   stop_count   - accepted stop tokens (saturating)
//   cycle_count  - cycles from first valid through DONE (saturating)
//   overflow     - sticky, token accepted while buffer full
//   err_token    - sticky, reserved control token accepted
//   timeout      - sticky watchdog flag, 0 when the watchdog is absent
module glb_stream_sink
  import glb_stream_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          STALL_N   = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     flush,
  input  logic [16:0]              data,
  input  logic                     valid,
  output logic                     ready,
  output logic                     done,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [16:0]              rd_data,
  output logic [15:0]              data_count,
  output logic [15:0]              stop_count,
  output logic [31:0]              cycle_count,
  output logic                     overflow,
  output logic                     err_token,
  output logic                     timeout
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [4:0]  STALL_THR = 5'(STALL_N);
  localparam logic [AW:0] FULL_PTR  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

  sink_state_t          state_q, state_d;
  token_kind_t          kind;
  logic [15:0]          lfsr;
  logic                 clear, stall, hs, full, take_done, idle_expire;
  logic [AW:0]          wptr;
  logic [TOKEN_W-1:0]   mem [DEPTH];

  // Flush is folded into the synchronous clear so both paths are identical.
  assign clear = !rst_n || flush;

  glb_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (!clear),
    .en    (clk_en),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  assign stall     = {1'b0, lfsr[3:0]} < STALL_THR;
  assign ready     = clk_en && (state_q != S_DONE) && !stall;
  assign hs        = valid && ready;
  assign kind      = decode_token(data);
  assign full      = (wptr == FULL_PTR);
  assign take_done = hs && (kind == KIND_DONE);

`ifdef GLB_STREAM_SINK_TIMEOUT_EN
  localparam int          IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

  logic [IW-1:0] idle_cnt;
  logic          timeout_q;

  // Expires on the edge that would bring the idle count up to TIMEOUT.
  assign idle_expire = clk_en && (state_q == S_RECV) && !hs && (idle_cnt == IDLE_LAST);

  // Idle counter only runs in RECV and restarts on every handshake.
  always_ff @(posedge clk) begin
    if (clear) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (clk_en) begin
      if (state_q != S_RECV || hs) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_ONE;
      end
      if (idle_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign idle_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A DONE accepted in the very first valid cycle skips RECV entirely.
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (take_done) begin
            state_d = S_DONE;
          end else if (valid) begin
            state_d = S_RECV;
          end
        end
        S_RECV: begin
          if (take_done || idle_expire) begin
            state_d = S_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Entries at or above wptr have never been written since the last clear,
  // so they read as 0 without having to clear the storage array.
  always_ff @(posedge clk) begin
    if (clear) begin
      wptr        <= '0;
      data_count  <= '0;
      stop_count  <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      err_token   <= 1'b0;
      rd_data     <= '0;
    end else if (clk_en) begin
      rd_data <= ({1'b0, rd_addr} < wptr) ? mem[rd_addr] : '0;

      if (state_q == S_IDLE && valid) begin
        cycle_count <= 32'd1;
      end else if (state_q == S_RECV && cycle_count != '1) begin
        cycle_count <= cycle_count + 32'd1;
      end

      if (hs) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wptr <= wptr + PTR_ONE;
        end
        case (kind)
          KIND_DATA: if (data_count != '1) data_count <= data_count + 16'd1;
          KIND_STOP: if (stop_count != '1) stop_count <= stop_count + 16'd1;
          KIND_DONE: done <= 1'b1;
          default:   err_token <= 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs && !full) begin
      mem[wptr[AW-1:0]] <= data;
    end
  end

endmodule

// File: tb/tb_glb_stream_sink.sv
// tb_glb_stream_sink
// Directed self-checking bench for glb_stream_sink. Three instances:
//   dut0 DEPTH=64 STALL_N=0 TIMEOUT=16, dut1 DEPTH=64 STALL_N=8,
//   dut2 DEPTH=4 STALL_N=0. Inputs driven and outputs sampled on negedge.
// Watchdog steps are selected by GLB_STREAM_SINK_TIMEOUT_EN.
module tb_glb_stream_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en      [3];
  logic        flush       [3];
  logic        valid       [3];
  logic [16:0] data        [3];
  logic [5:0]  rd_addr     [3];
  logic        ready       [3];
  logic        done        [3];
  logic        overflow    [3];
  logic        err_token   [3];
  logic        timeout     [3];
  logic [16:0] rd_data     [3];
  logic [15:0] data_count  [3];
  logic [15:0] stop_count  [3];
  logic [31:0] cycle_count [3];

  logic [15:0] lfsr_m;
  int          check_count = 0;
  int          pass_count  = 0;
  int          edges       = 0;
  logic [16:0] t1_tokens [5] = '{17'd3, 17'd5, 17'd7, 17'h10000, 17'h10100};

  glb_stream_sink #(.DEPTH(64), .STALL_N(0), .LFSR_SEED(16'hACE1), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en[0]), .flush(flush[0]),
    .data(data[0]), .valid(valid[0]), .ready(ready[0]), .done(done[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .data_count(data_count[0]),
    .stop_count(stop_count[0]), .cycle_count(cycle_count[0]),
    .overflow(overflow[0]), .err_token(err_token[0]), .timeout(timeout[0])
  );

  glb_stream_sink #(.DEPTH(64), .STALL_N(8), .LFSR_SEED(16'hACE1), .TIMEOUT(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en[1]), .flush(flush[1]),
    .data(data[1]), .valid(valid[1]), .ready(ready[1]), .done(done[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .data_count(data_count[1]),
    .stop_count(stop_count[1]), .cycle_count(cycle_count[1]),
    .overflow(overflow[1]), .err_token(err_token[1]), .timeout(timeout[1])
  );

  glb_stream_sink #(.DEPTH(4), .STALL_N(0), .LFSR_SEED(16'hACE1), .TIMEOUT(1024)) dut2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en[2]), .flush(flush[2]),
    .data(data[2]), .valid(valid[2]), .ready(ready[2]), .done(done[2]),
    .rd_addr(rd_addr[2][1:0]), .rd_data(rd_data[2]), .data_count(data_count[2]),
    .stop_count(stop_count[2]), .cycle_count(cycle_count[2]),
    .overflow(overflow[2]), .err_token(err_token[2]), .timeout(timeout[2])
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference backpressure LFSR for dut1, written from the tap list 16,14,13,11.
  always @(posedge clk) begin
    if (!rst_n || flush[1]) begin
      lfsr_m <= 16'hACE1;
    end else if (clk_en[1]) begin
      lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
  end

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one token and holds it until a handshake edge, bounded.
  task automatic applyStimulus(input int d, input logic [16:0] tok);
    int waited;
    bit sent;
    waited = 0;
    sent   = 1'b0;
    data[d]  = tok;
    valid[d] = 1'b1;
    while (!sent) begin
      if (d == 1) checkOutput("ready_vs_lfsr_model", 32'(ready[1]), 32'(lfsr_m[3:0] >= 4'd8));
      if (ready[d]) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        sent = 1'b1;
      end else if (waited >= 100) begin
        checkOutput("handshake_wait_expired", 32'd0, 32'd1);
        sent = 1'b1;
      end else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        waited++;
      end
    end
  endtask

  // Registered buffer read: address on one negedge, data the next.
  task automatic checkBuffer(input int d, input int addr, input logic [16:0] exp);
    rd_addr[d] = 6'(addr);
    @(negedge clk);
    checkOutput($sformatf("dut%0d_buf[%0d]", d, addr), 32'(rd_data[d]), 32'(exp));
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      clk_en[d]  = 1'b1;
      flush[d]   = 1'b0;
      valid[d]   = 1'b0;
      data[d]    = '0;
      rd_addr[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset values");
    checkOutput("rst_ready", 32'(ready[0]), 32'd1);
    checkOutput("rst_done", 32'(done[0]), 32'd0);
    checkOutput("rst_data_count", 32'(data_count[0]), 32'd0);
    checkOutput("rst_cycle_count", cycle_count[0], 32'd0);
    checkOutput("rst_flags", {29'd0, overflow[0], err_token[0], timeout[0]}, 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data[0]), 32'd0);
    // Seed 0xACE1 -> 0x5670 -> 0xAB38: low nibbles 1, 0, 8 against STALL_N=8.
    checkOutput("lfsr_step0_ready", 32'(ready[1]), 32'd0);
    @(negedge clk);
    checkOutput("lfsr_step1_ready", 32'(ready[1]), 32'd0);
    @(negedge clk);
    checkOutput("lfsr_step2_ready", 32'(ready[1]), 32'd1);

    $display("[TB] clk_en low holds state");
    clk_en[0] = 1'b0;
    valid[0]  = 1'b1;
    data[0]   = 17'd9;
    #1;
    checkOutput("clk_en_ready", 32'(ready[0]), 32'd0);
    @(negedge clk);
    checkOutput("clk_en_cycle_count", cycle_count[0], 32'd0);
    checkOutput("clk_en_data_count", 32'(data_count[0]), 32'd0);
    valid[0]  = 1'b0;
    clk_en[0] = 1'b1;
    @(negedge clk);

    $display("[TB] back-to-back stream, no stalls");
    for (int i = 0; i < 5; i++) begin
      checkOutput("t1_ready", 32'(ready[0]), 32'd1);
      applyStimulus(0, t1_tokens[i]);
    end
    valid[0] = 1'b0;
    checkOutput("t1_data_count", 32'(data_count[0]), 32'd3);
    checkOutput("t1_stop_count", 32'(stop_count[0]), 32'd1);
    checkOutput("t1_done", 32'(done[0]), 32'd1);
    checkOutput("t1_cycle_count", cycle_count[0], 32'd5);
    checkOutput("t1_ready_after_done", 32'(ready[0]), 32'd0);
    for (int i = 0; i < 5; i++) checkBuffer(0, i, t1_tokens[i]);
    checkBuffer(0, 5, 17'd0);

    $display("[TB] random backpressure, STALL_N=8");
    edges = 0;
    for (int i = 0; i < 20; i++) applyStimulus(1, 17'(100 + i));
    applyStimulus(1, 17'h10100);
    valid[1] = 1'b0;
    checkOutput("t2_done", 32'(done[1]), 32'd1);
    checkOutput("t2_data_count", 32'(data_count[1]), 32'd20);
    checkOutput("t2_cycle_count", cycle_count[1], 32'(edges));
    checkOutput("t2_some_stalls", 32'(edges > 21), 32'd1);
    checkOutput("t2_timeout", 32'(timeout[1]), 32'd0);
    for (int i = 0; i < 20; i++) checkBuffer(1, i, 17'(100 + i));
    checkBuffer(1, 20, 17'h10100);

    $display("[TB] DEPTH=4 overflow");
    for (int i = 0; i < 6; i++) applyStimulus(2, 17'(i + 1));
    applyStimulus(2, 17'h10100);
    valid[2] = 1'b0;
    checkOutput("t3_overflow", 32'(overflow[2]), 32'd1);
    checkOutput("t3_data_count", 32'(data_count[2]), 32'd6);
    checkOutput("t3_done", 32'(done[2]), 32'd1);
    checkOutput("t3_cycle_count", cycle_count[2], 32'd7);
    for (int i = 0; i < 4; i++) checkBuffer(2, i, 17'(i + 1));

    $display("[TB] reserved token, frozen after DONE");
    applyReset();
    applyStimulus(0, 17'h10200);
    applyStimulus(0, 17'h10100);
    data[0] = 17'd5;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4_ready_frozen", 32'(ready[0]), 32'd0);
      @(negedge clk);
    end
    valid[0] = 1'b0;
    checkOutput("t4_err_token", 32'(err_token[0]), 32'd1);
    checkOutput("t4_done", 32'(done[0]), 32'd1);
    checkOutput("t4_data_count", 32'(data_count[0]), 32'd0);
    checkOutput("t4_stop_count", 32'(stop_count[0]), 32'd0);
    checkOutput("t4_cycle_count", cycle_count[0], 32'd2);
    checkBuffer(0, 0, 17'h10200);
    checkBuffer(0, 1, 17'h10100);

    $display("[TB] flush mid-stream");
    applyReset();
    applyStimulus(0, 17'h11);
    applyStimulus(0, 17'h22);
    valid[0] = 1'b0;
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    checkOutput("t5_flush_data_count", 32'(data_count[0]), 32'd0);
    checkOutput("t5_flush_cycle_count", cycle_count[0], 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("t5_idle_cycle_count", cycle_count[0], 32'd0);
    applyStimulus(0, 17'h33);
    applyStimulus(0, 17'h10100);
    valid[0] = 1'b0;
    checkOutput("t5_data_count", 32'(data_count[0]), 32'd1);
    checkOutput("t5_cycle_count", cycle_count[0], 32'd2);
    checkOutput("t5_done", 32'(done[0]), 32'd1);
    checkBuffer(0, 0, 17'h33);
    checkBuffer(0, 1, 17'h10100);
    checkBuffer(0, 2, 17'd0);

    $display("[TB] idle after one token");
    applyReset();
    applyStimulus(0, 17'h44);
    valid[0] = 1'b0;
`ifdef GLB_STREAM_SINK_TIMEOUT_EN
    repeat (15) @(negedge clk);
    checkOutput("t6_timeout_before", 32'(timeout[0]), 32'd0);
    @(negedge clk);
    checkOutput("t6_timeout_at_16", 32'(timeout[0]), 32'd1);
    checkOutput("t6_done", 32'(done[0]), 32'd0);
    checkOutput("t6_ready", 32'(ready[0]), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("t6_timeout_sticky", 32'(timeout[0]), 32'd1);
`else
    repeat (20) @(negedge clk);
    checkOutput("t6_timeout_absent", 32'(timeout[0]), 32'd0);
    checkOutput("t6_still_ready", 32'(ready[0]), 32'd1);
    checkOutput("t6_done", 32'(done[0]), 32'd0);
    checkOutput("t6_cycle_count", cycle_count[0], 32'd21);
`endif

    $display("[TB] reset and flush together");
    rst_n    = 1'b0;
    flush[2] = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    flush[2] = 1'b0;
    checkOutput("t7_data_count", 32'(data_count[2]), 32'd0);
    checkOutput("t7_overflow", 32'(overflow[2]), 32'd0);
    checkOutput("t7_done", 32'(done[2]), 32'd0);
    checkOutput("t7_ready", 32'(ready[2]), 32'd1);
    checkBuffer(2, 0, 17'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
